// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: aligns core accesses onto a DW-wide memory bus,
// extends load results, and flags misaligned or timed-out accesses.
module load_store_unit #(
  parameter int DW  = 32,
  parameter int AW  = 32,
  parameter int TMO = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [3:0]      req_rd,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_data,
  output logic [3:0]      rsp_rd,
  output logic            rsp_err
);

  localparam int LB = DW / 8;
  localparam int OW = $clog2(LB);
  localparam logic [7:0] TMO_M1 = 8'(TMO - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state_reg, state_next;
  logic            ready_en_reg;
  logic            store_reg;
  logic [1:0]      size_reg;
  logic            signed_reg;
  logic [AW-1:0]   addr_reg;
  logic [DW-1:0]   wdata_reg;
  logic [3:0]      rd_reg;
  logic            err_reg;
  logic [DW-1:0]   rdata_reg;
  logic [7:0]      cnt_reg;

  logic            accept;
  logic            misaligned;
  logic [OW-1:0]   lane;
  logic [OW+2:0]   shamt;
  logic [DW-1:0]   size_mask;
  logic [7:0]      be_base;
  logic [DW-1:0]   shifted;
  logic            sign_bit;
  logic [DW-1:0]   load_result;

  assign accept = req_valid && req_ready;

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = (DW == 32) || (|req_addr[2:0]);
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = misaligned ? RESP : ACCESS;
      ACCESS:  if (mem_ack || cnt_reg == TMO_M1) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // ready_en_reg holds off req_ready until the first edge after reset release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en_reg <= 1'b0;
      store_reg    <= 1'b0;
      size_reg     <= 2'b00;
      signed_reg   <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rd_reg       <= 4'd0;
      err_reg      <= 1'b0;
      rdata_reg    <= '0;
      cnt_reg      <= 8'd0;
    end else begin
      ready_en_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            store_reg  <= req_store;
            size_reg   <= req_size;
            signed_reg <= req_signed;
            addr_reg   <= req_addr;
            wdata_reg  <= req_wdata;
            rd_reg     <= req_rd;
            err_reg    <= misaligned;
            rdata_reg  <= '0;
            cnt_reg    <= 8'd0;
          end
        end
        ACCESS: begin
          cnt_reg <= cnt_reg + 8'd1;
          if (mem_ack)                   rdata_reg <= store_reg ? '0 : load_result;
          else if (cnt_reg == TMO_M1)    err_reg   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign lane  = addr_reg[OW-1:0];
  assign shamt = {lane, 3'b000};

  always_comb begin
    size_mask = '1;
    be_base   = 8'hFF;
    sign_bit  = 1'b0;
    shifted   = mem_rdata >> shamt;
    case (size_reg)
      2'b00:   begin size_mask = DW'(8'hFF);         be_base = 8'h01; sign_bit = shifted[7];    end
      2'b01:   begin size_mask = DW'(16'hFFFF);      be_base = 8'h03; sign_bit = shifted[15];   end
      2'b10:   begin size_mask = DW'(32'hFFFF_FFFF); be_base = 8'h0F; sign_bit = shifted[31];   end
      default: begin size_mask = '1;                 be_base = 8'hFF; sign_bit = shifted[DW-1]; end
    endcase
    // full-width sizes have an all-ones mask, so the fill term vanishes for them
    load_result = (shifted & size_mask) | ((signed_reg && sign_bit) ? ~size_mask : '0);
  end

  assign req_ready = ready_en_reg && (state_reg == IDLE);
  assign mem_req   = (state_reg == ACCESS);
  assign mem_we    = mem_req && store_reg;
  assign mem_addr  = mem_req ? {addr_reg[AW-1:OW], {OW{1'b0}}} : '0;
  assign mem_be    = mem_req ? (be_base[LB-1:0] << lane) : '0;
  assign mem_wdata = mem_req ? ((wdata_reg & size_mask) << shamt) : '0;

  assign rsp_valid = (state_reg == RESP);
  assign rsp_err   = rsp_valid && err_reg;
  assign rsp_rd    = rsp_valid ? rd_reg : 4'd0;
  assign rsp_data  = (rsp_valid && !err_reg) ? rdata_reg : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: a DW=32/TMO=4 instance and a DW=64 instance driven through fixed vectors.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [3:0]  req_rd;
  logic        mem_ack;
  logic        v32, v64;
  logic [31:0] wd32, rdata32;
  logic [63:0] wd64, rdata64;

  logic        r32_ready, m32_req, m32_we, rs32_valid, rs32_err;
  logic [31:0] m32_addr, m32_wdata, rs32_data;
  logic [3:0]  m32_be, rs32_rd;

  logic        r64_ready, m64_req, m64_we, rs64_valid, rs64_err;
  logic [31:0] m64_addr;
  logic [63:0] m64_wdata, rs64_data;
  logic [7:0]  m64_be;
  logic [3:0]  rs64_rd;

  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit #(.DW(32), .AW(32), .TMO(4)) u32 (
    .clk(clk), .reset(reset),
    .req_valid(v32), .req_ready(r32_ready), .req_store(req_store), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(wd32), .req_rd(req_rd),
    .mem_req(m32_req), .mem_we(m32_we), .mem_addr(m32_addr), .mem_wdata(m32_wdata),
    .mem_be(m32_be), .mem_ack(mem_ack), .mem_rdata(rdata32),
    .rsp_valid(rs32_valid), .rsp_data(rs32_data), .rsp_rd(rs32_rd), .rsp_err(rs32_err)
  );

  load_store_unit #(.DW(64), .AW(32), .TMO(15)) u64 (
    .clk(clk), .reset(reset),
    .req_valid(v64), .req_ready(r64_ready), .req_store(req_store), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(wd64), .req_rd(req_rd),
    .mem_req(m64_req), .mem_we(m64_we), .mem_addr(m64_addr), .mem_wdata(m64_wdata),
    .mem_be(m64_be), .mem_ack(mem_ack), .mem_rdata(rdata64),
    .rsp_valid(rs64_valid), .rsp_data(rs64_data), .rsp_rd(rs64_rd), .rsp_err(rs64_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one request for a single edge, then scrambles the core inputs.
  task automatic issue(input logic st, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [63:0] wd,
                       input logic [3:0] rd, input logic wide);
    req_store = st; req_size = sz; req_signed = sg; req_addr = a;
    wd32 = wd[31:0]; wd64 = wd; req_rd = rd;
    if (wide) v64 = 1'b1; else v32 = 1'b1;
    @(negedge clk);
    v32 = 1'b0; v64 = 1'b0;
    req_addr = 32'hFFFF_FFFF; req_store = ~st; req_size = 2'b00; req_signed = ~sg;
    req_rd = 4'hF; wd32 = '1; wd64 = '1;
  endtask

  initial begin
    reset = 1'b0; v32 = 1'b0; v64 = 1'b0; mem_ack = 1'b0;
    req_store = 1'b0; req_size = 2'b00; req_signed = 1'b0; req_addr = '0; req_rd = '0;
    wd32 = '0; wd64 = '0; rdata32 = '0; rdata64 = '0;

    repeat (2) @(negedge clk);
    chk("rst_ready", r32_ready, 1'b0);
    chk("rst_mem_req", m32_req, 1'b0);
    chk("rst_mem_be", m32_be, 4'b0000);
    chk("rst_rsp_valid", rs32_valid, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", r32_ready, 1'b1);

    // signed byte load, lane 3
    issue(1'b0, 2'b00, 1'b1, 32'h103, 64'h0, 4'd5, 1'b0);
    chk("lb_mem_req", m32_req, 1'b1);
    chk("lb_mem_addr", m32_addr, 32'h100);
    chk("lb_mem_be", m32_be, 4'b1000);
    chk("lb_mem_we", m32_we, 1'b0);
    chk("lb_ready_busy", r32_ready, 1'b0);
    mem_ack = 1'b1; rdata32 = 32'h80FF_FF00;
    @(negedge clk);
    chk("lb_rsp_valid", rs32_valid, 1'b1);
    chk("lb_rsp_data", rs32_data, 32'hFFFF_FF80);
    chk("lb_rsp_rd", rs32_rd, 4'd5);
    chk("lb_rsp_err", rs32_err, 1'b0);
    chk("lb_resp_mem_req", m32_req, 1'b0);
    mem_ack = 1'b0;
    @(negedge clk);
    chk("lb_idle_valid", rs32_valid, 1'b0);
    chk("lb_idle_ready", r32_ready, 1'b1);

    // unsigned half load, lane 2
    issue(1'b0, 2'b01, 1'b0, 32'h102, 64'h0, 4'd6, 1'b0);
    chk("lhu_mem_be", m32_be, 4'b1100);
    mem_ack = 1'b1; rdata32 = 32'h80FF_FF00;
    @(negedge clk);
    chk("lhu_rsp_data", rs32_data, 32'h0000_80FF);
    mem_ack = 1'b0;
    @(negedge clk);

    // half store, lane 2, ack one cycle late
    issue(1'b1, 2'b01, 1'b0, 32'h22, 64'hDEAD_BEEF, 4'd3, 1'b0);
    chk("sh_mem_we", m32_we, 1'b1);
    chk("sh_mem_be", m32_be, 4'b1100);
    chk("sh_mem_wdata", m32_wdata, 32'hBEEF_0000);
    chk("sh_mem_addr", m32_addr, 32'h20);
    @(negedge clk);
    chk("sh_hold_req", m32_req, 1'b1);
    chk("sh_hold_wdata", m32_wdata, 32'hBEEF_0000);
    mem_ack = 1'b1; rdata32 = 32'h1234_5678;
    @(negedge clk);
    chk("sh_rsp_valid", rs32_valid, 1'b1);
    chk("sh_rsp_data", rs32_data, 32'h0);
    chk("sh_rsp_err", rs32_err, 1'b0);
    chk("sh_rsp_rd", rs32_rd, 4'd3);
    mem_ack = 1'b0;
    @(negedge clk);

    // misaligned word with a stray ack present throughout
    mem_ack = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 32'h41, 64'h0, 4'd9, 1'b0);
    chk("mis_rsp_valid", rs32_valid, 1'b1);
    chk("mis_rsp_err", rs32_err, 1'b1);
    chk("mis_rsp_rd", rs32_rd, 4'd9);
    chk("mis_rsp_data", rs32_data, 32'h0);
    chk("mis_mem_req", m32_req, 1'b0);
    @(negedge clk);
    chk("mis_idle_mem_req", m32_req, 1'b0);
    chk("mis_idle_valid", rs32_valid, 1'b0);
    chk("mis_idle_ready", r32_ready, 1'b1);
    mem_ack = 1'b0;

    // timeout with TMO=4
    issue(1'b0, 2'b10, 1'b1, 32'h40, 64'h0, 4'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tmo_mem_req%0d", i), m32_req, 1'b1);
      @(negedge clk);
    end
    chk("tmo_rsp_valid", rs32_valid, 1'b1);
    chk("tmo_rsp_err", rs32_err, 1'b1);
    chk("tmo_mem_req_low", m32_req, 1'b0);
    chk("tmo_rsp_data", rs32_data, 32'h0);
    @(negedge clk);

    // signed word load, then a back-to-back dword request on the 32-bit unit
    issue(1'b0, 2'b10, 1'b1, 32'h44, 64'h0, 4'd7, 1'b0);
    mem_ack = 1'b1; rdata32 = 32'h8000_0001;
    @(negedge clk);
    chk("lw_rsp_data", rs32_data, 32'h8000_0001);
    mem_ack = 1'b0;
    req_store = 1'b0; req_size = 2'b11; req_signed = 1'b0; req_addr = 32'h08; req_rd = 4'd4;
    v32 = 1'b1;
    @(negedge clk);
    chk("b2b_ready", r32_ready, 1'b1);
    chk("b2b_no_rsp", rs32_valid, 1'b0);
    @(negedge clk);
    v32 = 1'b0;
    chk("dw32_rsp_valid", rs32_valid, 1'b1);
    chk("dw32_rsp_err", rs32_err, 1'b1);
    chk("dw32_rsp_rd", rs32_rd, 4'd4);
    @(negedge clk);

    // 64-bit dword load
    issue(1'b0, 2'b11, 1'b0, 32'h08, 64'h0, 4'd1, 1'b1);
    chk("d64_mem_be", m64_be, 8'hFF);
    chk("d64_mem_addr", m64_addr, 32'h08);
    mem_ack = 1'b1; rdata64 = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    chk("d64_rsp_valid", rs64_valid, 1'b1);
    chk("d64_rsp_err", rs64_err, 1'b0);
    chk("d64_rsp_data", rs64_data, 64'h0123_4567_89AB_CDEF);
    mem_ack = 1'b0;
    @(negedge clk);

    // 64-bit signed word load from the upper half
    issue(1'b0, 2'b10, 1'b1, 32'h0C, 64'h0, 4'd8, 1'b1);
    chk("w64_mem_be", m64_be, 8'hF0);
    chk("w64_mem_addr", m64_addr, 32'h08);
    mem_ack = 1'b1; rdata64 = 64'h8000_0000_1234_5678;
    @(negedge clk);
    chk("w64_rsp_data", rs64_data, 64'hFFFF_FFFF_8000_0000);
    chk("w64_rsp_rd", rs64_rd, 4'd8);
    mem_ack = 1'b0;
    @(negedge clk);

    // reset in the middle of an access, late ack after release
    issue(1'b0, 2'b10, 1'b0, 32'h10, 64'h0, 4'hA, 1'b0);
    chk("mid_pre_req", m32_req, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid_rst_req", m32_req, 1'b0);
    chk("mid_rst_ready", r32_ready, 1'b0);
    chk("mid_rst_valid", rs32_valid, 1'b0);
    @(negedge clk);
    reset = 1'b1; mem_ack = 1'b1;
    @(negedge clk);
    chk("mid_rel_valid", rs32_valid, 1'b0);
    chk("mid_rel_ready", r32_ready, 1'b1);
    chk("mid_rel_req", m32_req, 1'b0);
    @(negedge clk);
    chk("mid_rel_valid2", rs32_valid, 1'b0);
    mem_ack = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
